// File: rtl/data_mem_arbiter.sv
// Round-robin two-port arbiter and access sequencer for the 16x16 data memory.
// Each access runs IDLE -> ACC -> RESP with registered grant, ack and read data.
module data_mem_arbiter #(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          REQ_A,
  input  logic          REQ_B,
  input  logic          WE_A,
  input  logic          WE_B,
  input  logic [AW-1:0] ADDR_A,
  input  logic [AW-1:0] ADDR_B,
  input  logic [DW-1:0] WDATA_A,
  input  logic [DW-1:0] WDATA_B,
  output logic          GNT_A,
  output logic          GNT_B,
  output logic          ACK_A,
  output logic          ACK_B,
  output logic [DW-1:0] RDATA_A,
  output logic [DW-1:0] RDATA_B,
  output logic          BUSY,
  output logic [AW-1:0] MEM_ADDR,
  output logic [DW-1:0] MEM_WDATA,
  output logic          MEM_WE,
  input  logic [DW-1:0] MEM_RDATA
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    RESP = 2'd2
  } state_t;

  // Port encoding for owner/last: 0 = port A, 1 = port B.
  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  state_t        state;
  logic          owner;
  logic          last;
  logic          lat_we;
  logic [AW-1:0] lat_addr;
  logic [DW-1:0] lat_wdata;
  logic [DW-1:0] rdata_a;
  logic [DW-1:0] rdata_b;
  logic          gnt_a;
  logic          gnt_b;
  logic          ack_a;
  logic          ack_b;
  logic          busy;
  logic          pick_b;

  // B wins when it is the only requester, or on a tie when A was served last.
  assign pick_b = REQ_B && (!REQ_A || (last == PORT_A));

  // Sequencer: arbitration, field latching, read capture and handshake outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      owner     <= PORT_A;
      last      <= PORT_B;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rdata_a   <= '0;
      rdata_b   <= '0;
      gnt_a     <= 1'b0;
      gnt_b     <= 1'b0;
      ack_a     <= 1'b0;
      ack_b     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      ack_a <= 1'b0;
      ack_b <= 1'b0;
      case (state)
        IDLE: begin
          if (REQ_A || REQ_B) begin
            owner     <= pick_b;
            lat_we    <= pick_b ? WE_B    : WE_A;
            lat_addr  <= pick_b ? ADDR_B  : ADDR_A;
            lat_wdata <= pick_b ? WDATA_B : WDATA_A;
            gnt_a     <= !pick_b;
            gnt_b     <= pick_b;
            busy      <= 1'b1;
            state     <= ACC;
          end
        end
        ACC: begin
          if (!lat_we) begin
            if (owner == PORT_B) rdata_b <= MEM_RDATA;
            else                 rdata_a <= MEM_RDATA;
          end
          ack_a <= (owner == PORT_A);
          ack_b <= (owner == PORT_B);
          state <= RESP;
        end
        RESP: begin
          last  <= owner;
          gnt_a <= 1'b0;
          gnt_b <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          gnt_a <= 1'b0;
          gnt_b <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign GNT_A     = gnt_a;
  assign GNT_B     = gnt_b;
  assign ACK_A     = ack_a;
  assign ACK_B     = ack_b;
  assign RDATA_A   = rdata_a;
  assign RDATA_B   = rdata_b;
  assign BUSY      = busy;
  assign MEM_ADDR  = lat_addr;
  assign MEM_WDATA = lat_wdata;

  // Reset gates the enable in the same cycle so an in-flight write is dropped.
  assign MEM_WE = (state == ACC) && lat_we && !RST;

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Two-port arbiter and access sequencer for the 16-word x 16-bit data memory of the 16-bit RISC processor. It shares the single memory port between port A (CPU load/store unit) and port B (program loader / debug port). It uses a req/ack handshake with round-robin fairness. It drives the memory's address, write-data and write-enable, and captures read data from the memory's 16:1 read multiplexer into a per-port response register.

## Interface
- DW, 16: data word width.
- AW, 4: address width (16 words).
- CLK  input  1  system clock; all state updates on rising edge.
- RST  input  1  synchronous, active-high reset.
- REQ_A / REQ_B  input  1  access request; held high until the matching ACK.
- WE_A / WE_B  input  1  1 = write, 0 = read; stable while REQ is high.
- ADDR_A / ADDR_B  input  AW  word address; stable while REQ is high.
- WDATA_A / WDATA_B  input  DW  write data; stable while REQ is high.
- GNT_A / GNT_B  output  1  port currently owns the memory (ACC and RESP states).
- ACK_A / ACK_B  output  1  one-cycle completion pulse.
- RDATA_A / RDATA_B  output  DW  registered read result; holds until next read by that port.
- BUSY  output  1  state != IDLE.
- MEM_ADDR  output  AW  to memory write decoder and read-mux select.
- MEM_WDATA  output  DW  to memory.
- MEM_WE  output  1  memory write enable; memory writes on the CLK edge ending the cycle.
- MEM_RDATA  input  DW  combinational read-mux output for MEM_ADDR.

## Operation
- FSM states: IDLE, ACC, RESP.
- IDLE:
  - No REQ: stay in IDLE.
  - Exactly one REQ: grant that port.
  - Both REQ: grant the port that is not LAST (round-robin).
  - On grant: latch winner's WE/ADDR/WDATA into internal registers, set OWNER, go to ACC.
- ACC:
  - MEM_ADDR = latched address; MEM_WDATA = latched data; MEM_WE = latched WE & !RST.
  - Read: MEM_RDATA is captured into RDATA_<OWNER> at the edge ending ACC.
  - Write: RDATA_<OWNER> is unchanged.
  - Always go to RESP.
- RESP:
  - ACK_<OWNER> = 1; LAST <= OWNER at the edge ending RESP.
  - Always go to IDLE.
- REQ of either port is ignored outside IDLE; requests arriving during ACC/RESP wait.
- Requester deasserts REQ in the cycle after ACK, or keeps it high with new fields to issue a back-to-back request.
- Outside ACC: MEM_WE = 0; MEM_ADDR and MEM_WDATA hold their last latched values.
- GNT_x = (state is ACC or RESP) and OWNER == x.
- Fairness: with both ports continuously requesting, grants strictly alternate A, B, A, B. No starvation.
- Reset (RST high at an edge):
  - state = IDLE, LAST = B (so A wins the first tie), OWNER = A.
  - Latched address/data, RDATA_A and RDATA_B = 0; all ACK/GNT/BUSY = 0.
- Reset mid-operation:
  - RST high during ACC forces MEM_WE low in that same cycle, so the write is suppressed.
  - The access is aborted, no ACK is issued, and the requester must re-request.

## Timing
- Fixed latency: REQ sampled in IDLE at edge N; ACC during cycle N+1; ACK and valid RDATA during cycle N+2; IDLE again at N+3.
- Throughput: one access per 3 cycles. A REQ held high through ACK is re-sampled at the edge ending IDLE.
- ACK_x is high for exactly one cycle per granted access and is never high for both ports at once.
- All outputs except MEM_WE are registered or decoded from state. MEM_WE is combinational from state and latched WE, gated by RST.
- No combinational path from any REQ/ADDR/WDATA input to any output.

## Test plan
- Read A: memory word 5 = 0xBEEF; REQ_A=1, WE_A=0, ADDR_A=5 at cycle 0 -> GNT_A in cycles 1-2, MEM_ADDR=5 in cycle 1, ACK_A and RDATA_A=0xBEEF in cycle 2, BUSY low in cycle 3.
- Write B then read A: B writes 0x1234 to addr 0xF -> MEM_WE high only in ACC cycle, ACK_B one pulse. A then reads addr 0xF -> RDATA_A=0x1234, RDATA_B unchanged.
- Tie after reset: REQ_A and REQ_B both held continuously -> grant order A, B, A, B, with ACK every 3 cycles. Each port sees an ACK every 6 cycles.
- Late arrival: REQ_B rises during A's ACC cycle -> B is not granted until the IDLE following A's RESP. A's ACK is unaffected.
- Reset mid-write: A writes 0xAAAA to addr 3 (old 0x0000); RST high in ACC cycle -> MEM_WE low that cycle, addr 3 still 0x0000, no ACK_A, all outputs 0 next cycle.
- Read during write: A reads addr 7 while B is queued to write addr 7 -> A returns the old value. B's write is visible to the next access.
